// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed SRAM, with wait states and two-cycle ERROR responses.
// Optional AHB_SRAM_SUB_PERF_EN adds saturating read/write/error transfer counters.
module ahb_sram_subordinate #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
`ifdef AHB_SRAM_SUB_PERF_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic [31:0]             err_count
`endif
);

  localparam int                    IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  accept, legal, done;
  logic [ADDR_WIDTH-1:0] offset;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  always_comb begin
    // Wrapping subtraction: addresses below BASE_ADDR land far above SPAN.
    offset    = HADDR - BASE_ADDR;
    accept    = HSEL & HTRANS[1] & HREADY;
    legal     = (offset < SPAN) && (HADDR[1:0] == 2'b00) && (HSIZE == 3'b010);
    done      = (state_q == S_IDLE && pend_q) || (state_q == S_WAIT && cnt_q == 4'd0);

    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_WAIT: HREADYOUT = (cnt_q == 4'd0);
      S_ERR1: begin HREADYOUT = 1'b0; HRESP = 1'b1; end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
    HRDATA = (done && !wr_q) ? mem[idx_q] : '0;

    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    wr_d    = wr_q;
    idx_d   = idx_q;
    case (state_q)
      S_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
              else               state_d = S_IDLE;
      S_ERR1: state_d = S_ERR2;
      S_ERR2: state_d = S_IDLE;
      default: ;
    endcase

    // A new address phase overrides the completion path (pipelined accept).
    if (accept) begin
      wr_d  = HWRITE;
      idx_d = offset[IDX_W+1:2];
      if (!legal) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = S_IDLE;
        pend_d  = 1'b1;
      end else begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
    end
  end

  // SRAM has no reset; a reset edge simply suppresses the pending commit.
  always_ff @(posedge clk) begin
    if (!reset && done && wr_q) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SRAM_SUB_PERF_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] err_count_q, err_count_d;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    if (done && !wr_q && rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
    if (done &&  wr_q && wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    if (state_q == S_ERR2 && err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign err_count = err_count_q;
`endif

endmodule
